// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding a single UART transmitter, with per-requester
// packet locking and an acknowledge watchdog on the transmitter busy flag.
module uart_tx_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               hb_clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               uart_tx_ready,
    output logic               uart_wen,
    output logic [7:0]         uart_wdata,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic             last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             found;
    logic [IW-1:0]    sel;
    logic [N_REQ-1:0] selOneHot;
    logic             transfer;
    logic             errSet;
    logic [IW-1:0]    nextPtr;
    int               scanIdx;

    // A locked owner is the only candidate; otherwise scan upward from rr_ptr with wrap.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        scanIdx   = 0;
        selOneHot = '0;
        if (lock_q) begin
            sel   = owner_q;
            found = req_valid[owner_q];
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                scanIdx = int'(rr_ptr_q) + k;
                if (scanIdx >= N_REQ) begin
                    scanIdx = scanIdx - N_REQ;
                end
                if (!found && req_valid[scanIdx[IW-1:0]]) begin
                    found = 1'b1;
                    sel   = scanIdx[IW-1:0];
                end
            end
        end
        selOneHot[sel] = 1'b1;
    end

    assign transfer  = (state_q == IDLE) && uart_tx_ready && found;
    assign req_ready = transfer ? selOneHot : '0;
    assign nextPtr   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        errSet   = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    wdata_d = req_data[{sel, 3'b000} +: 8];
                    grant_d = selOneHot;
                    owner_d = sel;
                    last_d  = req_last[sel];
                    lock_d  = ~req_last[sel];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!uart_tx_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(ACK_TIMEOUT)) begin
                        // Transmitter never went busy: drop the packet and move past the owner.
                        errSet   = 1'b1;
                        lock_d   = 1'b0;
                        grant_d  = '0;
                        rr_ptr_d = nextPtr;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (uart_tx_ready) begin
                    state_d = IDLE;
                    if (last_q) begin
                        lock_d   = 1'b0;
                        grant_d  = '0;
                        rr_ptr_d = nextPtr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = errSet ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wdata_q  <= '0;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign uart_wen    = (state_q == LOAD);
    assign uart_wdata  = wdata_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester queues drive the DUT, expected
// UART writes are queued per scenario and a monitor checks every write strobe.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic             hb_clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             uart_tx_ready;
    logic             uart_wen;
    logic [7:0]       uart_wdata;
    logic [N-1:0]     grant;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;

    typedef struct {
        logic [N-1:0] grant;
        logic [7:0]   data;
    } exp_t;

    exp_t         expQ[$];
    logic [8:0]   reqQ[N][$];
    logic         modelOn;
    int           testsRun;
    int           failCount;

    uart_tx_scheduler #(.N_REQ(N), .ACK_TIMEOUT(255)) dut (
        .hb_clk        (hb_clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_ready (uart_tx_ready),
        .uart_wen      (uart_wen),
        .uart_wdata    (uart_wdata),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
        reqQ[idx].push_back({last, data});
    endtask

    task automatic expectWrite(input int idx, input logic [7:0] data);
        exp_t e;
        e.grant = '0;
        e.grant[idx] = 1'b1;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge hb_clk);
        #2;
    endtask

    function automatic int queuedBytes();
        int total = 0;
        for (int i = 0; i < N; i++) total += reqQ[i].size();
        return total;
    endfunction

    task automatic waitWen(input string name);
        int c = 0;
        do begin
            @(negedge hb_clk);
            c++;
        end while (uart_wen !== 1'b1 && c < 200);
        checkOutput(name, {31'd0, uart_wen}, 32'd1);
    endtask

    // Waits until every expected write has appeared and the DUT is idle; with
    // includeQueued it also waits for all requester queues to empty.
    task automatic waitDrain(input string name, input bit includeQueued);
        int c = 0;
        int pending;
        do begin
            @(negedge hb_clk);
            c++;
            pending = expQ.size() + int'(busy) + (includeQueued ? queuedBytes() : 0);
        end while (pending != 0 && c < 2000);
        checkOutput(name, pending, 0);
    endtask

    // Requesters: present the front byte of each queue, pop it after a handshake.
    initial begin
        logic [N-1:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge hb_clk);
            hs = req_valid & req_ready;
            @(posedge hb_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
                if (reqQ[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[8*i +: 8]   = reqQ[i][0][7:0];
                    req_last[i]          = reqQ[i][0][8];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[8*i +: 8]   = 8'h00;
                    req_last[i]          = 1'b0;
                end
            end
        end
    end

    // Transmitter: goes busy one cycle after the write strobe, idle again 20 cycles later.
    initial begin
        uart_tx_ready = 1'b1;
        forever begin
            @(negedge hb_clk);
            if (uart_wen === 1'b1 && modelOn) begin
                @(posedge hb_clk);
                #1 uart_tx_ready = 1'b0;
                repeat (20) @(posedge hb_clk);
                #1 uart_tx_ready = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge hb_clk);
            if (uart_wen === 1'b1) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_wen: got data 0x%0h grant 0x%0h, expected no write", uart_wdata, grant);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wen_data", {24'd0, uart_wdata}, {24'd0, e.data});
                    checkOutput("wen_grant", {28'd0, grant}, {28'd0, e.grant});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        testsRun  = 0;
        failCount = 0;
        modelOn   = 1'b1;
        err_clr   = 1'b0;
        rst_n     = 1'b0;

        // Reset values
        repeat (3) @(posedge hb_clk);
        #1;
        checkOutput("rst_grant", {28'd0, grant}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_wen", {31'd0, uart_wen}, 32'd0);
        checkOutput("rst_wdata", {24'd0, uart_wdata}, 32'd0);
        checkOutput("rst_err", {31'd0, timeout_err}, 32'd0);
        checkOutput("rst_ready", {28'd0, req_ready}, 32'd0);
        @(negedge hb_clk);
        rst_n = 1'b1;
        tick();

        // Single byte from requester 1
        applyStimulus(1, 8'h55, 1'b1);
        expectWrite(1, 8'h55);
        @(negedge hb_clk);
        @(negedge hb_clk);
        checkOutput("single_ready", {28'd0, req_ready}, 32'h2);
        @(negedge hb_clk);
        checkOutput("single_wen", {31'd0, uart_wen}, 32'd1);
        @(negedge hb_clk);
        @(negedge hb_clk);
        checkOutput("single_busy", {31'd0, busy}, 32'd1);
        checkOutput("single_grant_hold", {28'd0, grant}, 32'h2);
        waitDrain("single_drain", 1'b1);
        checkOutput("single_grant_clr", {28'd0, grant}, 32'd0);

        // rr_ptr now 2: requesters 1 and 3 together serve 3 first
        tick();
        applyStimulus(1, 8'h11, 1'b1);
        applyStimulus(3, 8'h33, 1'b1);
        expectWrite(3, 8'h33);
        expectWrite(1, 8'h11);
        waitDrain("rrptr_drain", 1'b1);

        // Round-robin from reset: 0,1,2,3,0
        @(negedge hb_clk);
        rst_n = 1'b0;
        @(negedge hb_clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 8'hA0, 1'b1);
        applyStimulus(0, 8'hA4, 1'b1);
        applyStimulus(1, 8'hB1, 1'b1);
        applyStimulus(2, 8'hC2, 1'b1);
        applyStimulus(3, 8'hD3, 1'b1);
        expectWrite(0, 8'hA0);
        expectWrite(1, 8'hB1);
        expectWrite(2, 8'hC2);
        expectWrite(3, 8'hD3);
        expectWrite(0, 8'hA4);
        waitDrain("rr_drain", 1'b1);

        // Packet lock: requester 0 holds the UART across a gap in its packet
        @(negedge hb_clk);
        rst_n = 1'b0;
        @(negedge hb_clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 8'hE1, 1'b0);
        applyStimulus(1, 8'hF1, 1'b1);
        expectWrite(0, 8'hE1);
        waitDrain("lock_first", 1'b0);
        repeat (30) @(negedge hb_clk);
        checkOutput("lock_grant_idle", {28'd0, grant}, 32'h1);
        checkOutput("lock_ready_blocked", {28'd0, req_ready}, 32'd0);
        checkOutput("lock_req1_waiting", reqQ[1].size(), 32'd1);
        tick();
        applyStimulus(0, 8'hE2, 1'b0);
        applyStimulus(0, 8'hE3, 1'b1);
        expectWrite(0, 8'hE2);
        expectWrite(0, 8'hE3);
        expectWrite(1, 8'hF1);
        waitDrain("lock_drain", 1'b1);
        checkOutput("lock_grant_clr", {28'd0, grant}, 32'd0);

        // Acknowledge timeout with lock set, then error clear
        @(negedge hb_clk);
        rst_n = 1'b0;
        @(negedge hb_clk);
        rst_n = 1'b1;
        modelOn = 1'b0;
        tick();
        applyStimulus(2, 8'h3C, 1'b0);
        expectWrite(2, 8'h3C);
        waitWen("to_wen");
        repeat (255) @(negedge hb_clk);
        checkOutput("to_err_early", {31'd0, timeout_err}, 32'd0);
        checkOutput("to_busy_early", {31'd0, busy}, 32'd1);
        @(negedge hb_clk);
        checkOutput("to_err_set", {31'd0, timeout_err}, 32'd1);
        checkOutput("to_idle", {31'd0, busy}, 32'd0);
        checkOutput("to_grant_clr", {28'd0, grant}, 32'd0);
        @(posedge hb_clk);
        #1 err_clr = 1'b1;
        @(posedge hb_clk);
        #1 err_clr = 1'b0;
        @(negedge hb_clk);
        checkOutput("to_err_clr", {31'd0, timeout_err}, 32'd0);

        // Lock gone and rr_ptr moved to 3
        modelOn = 1'b1;
        tick();
        applyStimulus(1, 8'h1A, 1'b1);
        applyStimulus(3, 8'h3A, 1'b1);
        expectWrite(3, 8'h3A);
        expectWrite(1, 8'h1A);
        waitDrain("to_after_drain", 1'b1);

        // Clear coinciding with a new timeout: set wins
        modelOn = 1'b0;
        tick();
        applyStimulus(0, 8'h0F, 1'b1);
        expectWrite(0, 8'h0F);
        waitWen("clr_wen");
        repeat (255) @(negedge hb_clk);
        err_clr = 1'b1;
        @(posedge hb_clk);
        #1 err_clr = 1'b0;
        @(negedge hb_clk);
        checkOutput("clr_set_wins", {31'd0, timeout_err}, 32'd1);
        checkOutput("clr_idle", {31'd0, busy}, 32'd0);

        // Reset in WAIT_DONE with lock held, then requester 2 alone
        modelOn = 1'b1;
        tick();
        applyStimulus(0, 8'hC0, 1'b0);
        expectWrite(0, 8'hC0);
        waitWen("mid_wen");
        repeat (3) @(negedge hb_clk);
        checkOutput("mid_busy", {31'd0, busy}, 32'd1);
        checkOutput("mid_grant", {28'd0, grant}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_grant", {28'd0, grant}, 32'd0);
        checkOutput("mid_rst_wen", {31'd0, uart_wen}, 32'd0);
        checkOutput("mid_rst_wdata", {24'd0, uart_wdata}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, timeout_err}, 32'd0);
        checkOutput("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        @(negedge hb_clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(2, 8'h2D, 1'b1);
        expectWrite(2, 8'h2D);
        waitDrain("mid_after_drain", 1'b1);
        checkOutput("mid_final_grant", {28'd0, grant}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
